// File: rtl/ccu2_serial_sub_pkg.sv
// Shared types and constants for the 2-bit-per-cycle serial subtractor.
package ccu2_serial_sub_pkg;

  localparam int SLICE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SLICE-1:0] d;
    logic             bout;
  } slice_res_t;

endpackage

// File: rtl/ccu2_serial_sub_sub2_slice.sv
// 2-bit combinational borrow slice: d = a - b - bin, bout set on underflow.
module sub2_slice
  import ccu2_serial_sub_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bin,
  output logic [1:0] d,
  output logic       bout
);

  logic [2:0] diff;
  slice_res_t res;

  // The extra MSB of the 3-bit difference becomes 1 exactly when the slice underflows.
  assign diff = {1'b0, a} - {1'b0, b} - {2'b00, bin};
  assign res  = '{d: diff[1:0], bout: diff[2]};
  assign d    = res.d;
  assign bout = res.bout;

endmodule

// File: rtl/ccu2_serial_sub.sv
// Serial subtractor: D = A - B - BIN, two bits per cycle, LSB slice first.
module ccu2_serial_sub
  import ccu2_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       slice_d;
  logic             slice_bout;
  logic             accept;

  sub2_slice u_slice (
    .a    (a_reg[1:0]),
    .b    (b_reg[1:0]),
    .bin  (borrow_reg),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Each new slice enters at the MSB end, so after STEPS cycles the LSB slice sits at bit 0.
  generate
    if (WIDTH == SLICE) begin : g_res_single
      assign res_next = slice_d;
    end else begin : g_res_shift
      assign res_next = {slice_d, res_reg[WIDTH-1:SLICE]};
    end
  endgenerate

  assign accept = start && (state_reg == ST_IDLE || state_reg == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      d          <= '0;
      bout       <= 1'b0;
      zero       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          a_reg      <= a_reg >> SLICE;
          b_reg      <= b_reg >> SLICE;
          res_reg    <= res_next;
          borrow_reg <= slice_bout;
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_FIN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FIN: begin
          d         <= res_reg;
          bout      <= borrow_reg;
          zero      <= (res_reg == '0);
          done      <= 1'b1;
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        ST_IDLE: ;
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
      // Acceptance in FIN overrides the return to IDLE so back-to-back operations lose no cycle.
      if (accept) begin
        a_reg      <= a;
        b_reg      <= b;
        borrow_reg <= bin;
        res_reg    <= '0;
        cnt_reg    <= '0;
        state_reg  <= ST_RUN;
        busy       <= 1'b1;
      end
    end
  end

endmodule
